// File: rtl/program_loader_if.sv
// program_loader_if
//   Bundles the control, byte-stream and instruction-memory write signals of
//   the program loader so they travel as one port.
//
//   Stream handshake: a byte moves on a rising clk edge where s_valid=1 and
//   s_ready=1. The source holds s_data stable while s_valid=1 and s_ready=0.
//   The loader never waits on s_valid before raising s_ready.
//
//   Signals
//     load_req            host -> loader  one-cycle pulse arming a new load
//     abort               host -> loader  synchronous abort of a busy load
//     s_data / s_valid    host -> loader  stream byte and its qualifier
//     s_ready             loader -> host  loader takes a byte this cycle
//     I_MEM_Write_Enable  loader -> mem   one-cycle write strobe
//     I_MEM_Data_In       loader -> mem   32-bit word being written
//     I_MEM_Write_Addr    loader -> mem   ADDR_W-bit write address
//     start               loader -> core  level-held execution enable
//     busy                loader -> host  load in progress
//     err                 loader -> host  sticky error flag
//     state_dbg           loader -> debug current FSM state encoding
//
//   Modports: master (host/bench side), slave (loader side).
interface program_loader_if #(
    parameter int ADDR_W = 16
);
    logic              load_req;
    logic              abort;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              I_MEM_Write_Enable;
    logic [31:0]       I_MEM_Data_In;
    logic [ADDR_W-1:0] I_MEM_Write_Addr;
    logic              start;
    logic              busy;
    logic              err;
    logic [3:0]        state_dbg;

    modport master (
        output load_req, abort, s_data, s_valid,
        input  s_ready, I_MEM_Write_Enable, I_MEM_Data_In, I_MEM_Write_Addr,
        input  start, busy, err, state_dbg
    );

    modport slave (
        input  load_req, abort, s_data, s_valid,
        output s_ready, I_MEM_Write_Enable, I_MEM_Data_In, I_MEM_Write_Addr,
        output start, busy, err, state_dbg
    );
endinterface

// File: rtl/program_loader.sv
// program_loader
//   Receives a framed byte stream (LEN_HI, LEN_LO, then N big-endian 32-bit
//   words) and writes the words into instruction memory at BASE_ADDR,
//   BASE_ADDR+1, ... using one-cycle write strobes. When the frame completes
//   it raises the level-held start that launches the datapath.
//
//   Optional feature (macro PROGRAM_LOADER_CHECKSUM_EN): the frame carries
//   one trailer byte equal to the XOR of all preceding frame bytes; a
//   mismatch ends the load in ERR instead of starting execution.
//
//   Parameters
//     ADDR_W     width of the I_MEM write address
//     BASE_ADDR  address of the first loaded word
//
//   Ports
//     clk  rising-edge system clock
//     rst  asynchronous active-low reset
//     bus  program_loader_if.slave (handshake, memory write, status)
module program_loader #(
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEN_HI = 4'd1,
        S_LEN_LO = 4'd2,
        S_DATA   = 4'd3,
        S_WRITE  = 4'd4,
        S_FIN    = 4'd5,
        S_DONE   = 4'd6,
        S_ERR    = 4'd7
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , S_CSUM = 4'd8
`endif
    } state_t;

    // State entered once the payload is complete (or N=0).
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_FIN;
`endif

    // Largest word count that fits between BASE_ADDR and the top of memory.
    localparam logic [32:0] LEN_LIMIT = 33'((64'd1 << ADDR_W) - 64'(BASE_ADDR));

    state_t            state_q, state_d;
    logic [15:0]       len_q;
    logic [1:0]        byte_cnt_q;
    // One bit wider than the address so N = 2^ADDR_W does not wrap.
    logic [ADDR_W:0]   word_cnt_q;
    logic [23:0]       asm_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] waddr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic        stream_st;
    logic        busy_st;
    logic        take_req;
    logic        s_ready;
    logic        xfer;
    logic [15:0] n_new;
    logic        last_word;

    always_comb begin
        stream_st = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        stream_st = stream_st || (state_q == S_CSUM);
`endif
        busy_st   = stream_st || (state_q == S_WRITE);
        take_req  = bus.load_req &&
                    ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
        // Withholding s_ready while abort is high keeps a byte offered in the
        // abort cycle from being consumed, so abort always wins.
        s_ready   = stream_st && !bus.abort;
        xfer      = s_ready && bus.s_valid;
        n_new     = {len_q[15:8], bus.s_data};
        last_word = (33'(word_cnt_q) + 33'd1) == 33'(len_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: if (bus.load_req) state_d = S_LEN_HI;
            S_LEN_HI: if (xfer) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (33'(n_new) > LEN_LIMIT) state_d = S_ERR;
                    else if (n_new == 16'd0)    state_d = S_TAIL;
                    else                        state_d = S_DATA;
                end
            end
            S_DATA: if (xfer && byte_cnt_q == 2'd3) state_d = S_WRITE;
            S_WRITE: state_d = last_word ? S_TAIL : S_DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: if (xfer) state_d = (bus.s_data == csum_q) ? S_FIN : S_ERR;
`endif
            S_FIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (bus.abort && busy_st) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (take_req) begin
                len_q      <= '0;
                byte_cnt_q <= '0;
                word_cnt_q <= '0;
                asm_q      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                csum_q     <= '0;
`endif
            end
            if (xfer) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                csum_q <= csum_q ^ bus.s_data;
`endif
                case (state_q)
                    S_LEN_HI: len_q[15:8] <= bus.s_data;
                    S_LEN_LO: len_q[7:0]  <= bus.s_data;
                    S_DATA: begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        asm_q      <= {asm_q[15:0], bus.s_data};
                        // Word and address are captured as the 4th byte lands
                        // and then hold until the next word completes.
                        if (byte_cnt_q == 2'd3) begin
                            wdata_q <= {asm_q, bus.s_data};
                            waddr_q <= ADDR_W'(BASE_ADDR) + word_cnt_q[ADDR_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
            if (state_q == S_WRITE) word_cnt_q <= word_cnt_q + 1'b1;
        end
    end

    assign bus.s_ready            = s_ready;
    assign bus.I_MEM_Write_Enable = (state_q == S_WRITE);
    assign bus.I_MEM_Data_In      = wdata_q;
    assign bus.I_MEM_Write_Addr   = waddr_q;
    assign bus.start              = (state_q == S_DONE);
    assign bus.busy               = busy_st;
    assign bus.err                = (state_q == S_ERR);
    assign bus.state_dbg          = state_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    localparam int ADDR_W  = 16;
    localparam int BASE_HI = 32'hFFF0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic       load_req = 1'b0;
    logic       abort    = 1'b0;
    logic       s_valid  = 1'b0;
    logic [7:0] s_data   = 8'h00;
    logic       hi_sel   = 1'b0;   // route load_req/abort to the high-base loader

    program_loader_if #(.ADDR_W(ADDR_W)) bus ();
    program_loader_if #(.ADDR_W(ADDR_W)) bus_hi ();

    assign bus.load_req    = load_req & ~hi_sel;
    assign bus.abort       = abort & ~hi_sel;
    assign bus.s_data      = s_data;
    assign bus.s_valid     = s_valid;
    assign bus_hi.load_req = load_req & hi_sel;
    assign bus_hi.abort    = abort & hi_sel;
    assign bus_hi.s_data   = s_data;
    assign bus_hi.s_valid  = s_valid;

    program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_HI)) u_dut_hi (
        .clk(clk), .rst(rst), .bus(bus_hi)
    );

    logic s_ready_sel;
    assign s_ready_sel = hi_sel ? bus_hi.s_ready : bus.s_ready;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [47:0] exp_q[$];      // {addr, data} of each expected write
    logic [47:0] exp_e;
    int wr_count    = 0;
    int hi_wr_count = 0;
    int last_wr_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic fail_now(input string name, input int act, input int req);
        n_checks++;
        $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    always @(negedge clk) begin
        if (bus.I_MEM_Write_Enable === 1'b1) begin
            wr_count++;
            last_wr_cyc = cyc;
            check("s_ready_in_write", 64'(bus.s_ready), 64'd0);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_write", 1, 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("write_addr", 64'(bus.I_MEM_Write_Addr), 64'(exp_e[47:32]));
                check("write_data", 64'(bus.I_MEM_Data_In), 64'(exp_e[31:0]));
            end
        end
        if (bus_hi.I_MEM_Write_Enable === 1'b1) hi_wr_count++;
    end

    // ---------------- reference model ----------------
    logic [31:0] words[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  frame_csum;

    function automatic logic len_fits(input int n, input int base);
        return n <= (1 << ADDR_W) - base;
    endfunction

    task automatic build_frame(input logic bad);
        logic [7:0] x;
        int n;
        n = words.size();
        tx_q.delete();
        tx_q.push_back(8'(n >> 8));
        tx_q.push_back(8'(n));
        foreach (words[i]) begin
            for (int k = 3; k >= 0; k--) tx_q.push_back(8'(words[i] >> (8 * k)));
        end
        x = 8'h00;
        foreach (tx_q[i]) x = x ^ tx_q[i];
        if (bad) x = x ^ 8'h01;
        frame_csum = x;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        tx_q.push_back(frame_csum);
`endif
    endtask

    task automatic expect_writes();
        if (len_fits(words.size(), 0)) begin
            foreach (words[i]) exp_q.push_back({16'(i), words[i]});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            tick();
        end
        s_data  = b;
        s_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            ok = s_ready_sel;
            tick();
            if (ok === 1'b1) begin
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        fail_now("s_ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input int gap_mode);
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0);
        end
    endtask

    task automatic wait_outcome(output int seen);
        int t;
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (bus.start === 1'b1 || bus.err === 1'b1) break;
            t++;
        end
        if (t >= 100) fail_now("outcome_timeout", t, 0);
        seen = cyc;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_load(input string tag, input int gap_mode, input logic bad,
                            input logic exp_start, input logic exp_err);
        int seen;
        int n_exp;
        build_frame(bad);
        expect_writes();
        n_exp = len_fits(words.size(), 0) ? words.size() : 0;
        wr_count = 0;
        pulse_load();
        check({tag, "_busy_on_req"}, 64'(bus.busy), 64'd1);
        check({tag, "_start_cleared"}, 64'(bus.start), 64'd0);
        check({tag, "_err_cleared"}, 64'(bus.err), 64'd0);
        send_frame(gap_mode);
        wait_outcome(seen);
        check({tag, "_start"}, 64'(bus.start), 64'(exp_start));
        check({tag, "_err"}, 64'(bus.err), 64'(exp_err));
        check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        check({tag, "_write_count"}, 64'(wr_count), 64'(n_exp));
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        if (n_exp > 0) check({tag, "_start_latency"}, 64'(seen - last_wr_cyc), 64'd2);
`endif
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        int          n;
        logic [31:0] w0, w1, w2;
        int          gap_mode;
        logic        bad_csum;
        logic        exp_start;
        logic        exp_err;
    } vec_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam int NV = 5;
`else
    localparam int NV = 4;
`endif
    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        int n;
        logic [31:0] w;

        vecs[0] = '{"nominal", 3, 32'h0000_0000, 32'hC821_0005, 32'hC842_000A, 0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"backpressure", 3, 32'h0000_0000, 32'hC821_0005, 32'hC842_000A, 1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"empty", 0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"reload", 1, 32'hE40F_0001, 32'h0, 32'h0, 0, 1'b0, 1'b1, 1'b0};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        vecs[4] = '{"bad_csum", 3, 32'h0000_0000, 32'hC821_0005, 32'hC842_000A, 0, 1'b1, 1'b0, 1'b1};
`endif

        // reset state
        #12;
        check("rst_we", 64'(bus.I_MEM_Write_Enable), 64'd0);
        check("rst_data", 64'(bus.I_MEM_Data_In), 64'd0);
        check("rst_addr", 64'(bus.I_MEM_Write_Addr), 64'd0);
        check("rst_start", 64'(bus.start), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // table-driven loads (each runs from the previous one's end state)
        for (int v = 0; v < NV; v++) begin
            words.delete();
            if (vecs[v].n > 0) words.push_back(vecs[v].w0);
            if (vecs[v].n > 1) words.push_back(vecs[v].w1);
            if (vecs[v].n > 2) words.push_back(vecs[v].w2);
            run_load(vecs[v].name, vecs[v].gap_mode, vecs[v].bad_csum,
                     vecs[v].exp_start, vecs[v].exp_err);
        end

        // overflow frame on the loader based at FFF0: 17 words exceed 16 slots
        hi_sel = 1'b1;
        hi_wr_count = 0;
        words.delete();
        build_frame(1'b0);
        tx_q[1] = 8'h11;
        pulse_load();
        send_byte(tx_q[0], 0);
        send_byte(tx_q[1], 0);
        repeat (3) @(negedge clk);
        check("ovf_err", 64'(bus_hi.err), 64'd1);
        check("ovf_start", 64'(bus_hi.start), 64'd0);
        check("ovf_busy", 64'(bus_hi.busy), 64'd0);
        check("ovf_writes", 64'(hi_wr_count), 64'd0);
        pulse_load();
        check("ovf_err_cleared", 64'(bus_hi.err), 64'd0);
        check("ovf_busy_rearmed", 64'(bus_hi.busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ovf_abort_busy", 64'(bus_hi.busy), 64'd0);
        hi_sel = 1'b0;

        // abort after the second word
        words.delete();
        words.push_back(32'hA1A2_A3A4);
        words.push_back(32'hB1B2_B3B4);
        words.push_back(32'hC1C2_C3C4);
        build_frame(1'b0);
        exp_q.push_back({16'd0, words[0]});
        exp_q.push_back({16'd1, words[1]});
        wr_count = 0;
        pulse_load();
        for (int i = 0; i < 10; i++) send_byte(tx_q[i], 0);
        tick();
        abort = 1'b1;
        s_valid = 1'b1;
        s_data = tx_q[10];
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_start", 64'(bus.start), 64'd0);
        check("abort_err", 64'(bus.err), 64'd0);
        repeat (6) tick();
        s_valid = 1'b0;
        check("abort_write_count", 64'(wr_count), 64'd2);
        check("abort_pending", 64'(exp_q.size()), 64'd0);

        // async reset in the middle of a word
        words.delete();
        words.push_back(32'h1122_3344);
        words.push_back(32'h5566_7788);
        build_frame(1'b0);
        pulse_load();
        for (int i = 0; i < 4; i++) send_byte(tx_q[i], 0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_we", 64'(bus.I_MEM_Write_Enable), 64'd0);
        check("arst_data", 64'(bus.I_MEM_Data_In), 64'd0);
        check("arst_addr", 64'(bus.I_MEM_Write_Addr), 64'd0);
        check("arst_start", 64'(bus.start), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_err", 64'(bus.err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        words.delete();
        words.push_back(32'h0000_0000);
        words.push_back(32'hC821_0005);
        words.push_back(32'hC842_000A);
        run_load("post_reset", 0, 1'b0, 1'b1, 1'b0);

        // randomized frames against the model
        for (int r = 0; r < 20; r++) begin
            words.delete();
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                words.push_back(w);
            end
            run_load("random", 2, 1'b0, len_fits(n, 0), !len_fits(n, 0));
        end

        check("final_pending", 64'(exp_q.size()), 64'd0);
        seen = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
